// File: rtl/m_ex_wakeup_queue_pkg.sv
// Shared types and defaults for the M->EX wakeup queue.
// Optional flush support is enabled by defining M_EX_Q_FLUSH_EN.
package m_ex_q_pkg;
    localparam int DEPTH_D    = 8;
    localparam int NUM_OPS_D  = 4;
    localparam int OP_W_D     = 64;
    localparam int TAG_W_D    = 8;
    localparam int ID_W_D     = 7;
    localparam int NUM_WAKE_D = 4;
    localparam int NUM_PROS_D = 7;

    localparam logic [TAG_W_D-1:0] TAG_RESOLVED = '0;

    typedef struct packed {
        logic                          valid;
        logic [ID_W_D-1:0]             id;
        logic [NUM_WAKE_D-1:0]         need;
        logic [NUM_WAKE_D-1:0]         wake;
        logic [NUM_OPS_D*OP_W_D-1:0]   ops;
        logic [NUM_OPS_D*TAG_W_D-1:0]  tags;
    } entry_t;

    function automatic logic entry_ready(entry_t e);
        return e.valid && (&(e.wake | ~e.need)) && (e.tags == '0);
    endfunction
endpackage

// File: rtl/m_ex_wakeup_queue_if.sv
// Enqueue/issue handshake bundle for the M->EX wakeup queue.
// Flush (M_EX_Q_FLUSH_EN) is a plain top port, not part of this bundle.
interface m_ex_wakeup_queue_if
    import m_ex_q_pkg::*;
#(
    parameter int ID_W     = ID_W_D,
    parameter int NUM_WAKE = NUM_WAKE_D,
    parameter int NUM_OPS  = NUM_OPS_D,
    parameter int OP_W     = OP_W_D,
    parameter int TAG_W    = TAG_W_D
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ID_W-1:0]          in_id;
    logic [NUM_WAKE-1:0]      in_need;
    logic [NUM_OPS*OP_W-1:0]  in_ops;
    logic [NUM_OPS*TAG_W-1:0] in_tags;
    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_id;
    logic [NUM_OPS*OP_W-1:0]  out_ops;

    modport master (
        output in_valid, in_id, in_need, in_ops, in_tags, out_ready,
        input  in_ready, out_valid, out_id, out_ops
    );
    modport slave (
        input  in_valid, in_id, in_need, in_ops, in_tags, out_ready,
        output in_ready, out_valid, out_id, out_ops
    );
endinterface

// File: rtl/m_ex_wakeup_queue_fwd.sv
// Operand forwarding: per-operand tag compare against all prospects.
// Lowest-index matching prospect wins; resolved operands never rematch.
module m_ex_q_fwd
    import m_ex_q_pkg::*;
#(
    parameter int NUM_OPS  = NUM_OPS_D,
    parameter int OP_W     = OP_W_D,
    parameter int TAG_W    = TAG_W_D,
    parameter int NUM_PROS = NUM_PROS_D
) (
    input  logic [NUM_OPS*OP_W-1:0]   ops,
    input  logic [NUM_OPS*TAG_W-1:0]  tags,
    input  logic [NUM_PROS*OP_W-1:0]  pros_data,
    input  logic [NUM_PROS*TAG_W-1:0] pros_tag,
    output logic [NUM_OPS*OP_W-1:0]   ops_n,
    output logic [NUM_OPS*TAG_W-1:0]  tags_n
);
    always_comb begin
        ops_n  = ops;
        tags_n = tags;
        for (int o = 0; o < NUM_OPS; o++) begin
            if (tags[o*TAG_W +: TAG_W] != TAG_W'(TAG_RESOLVED)) begin
                // Walk high to low so the lowest match is written last.
                for (int p = NUM_PROS - 1; p >= 0; p--) begin
                    if (pros_tag[p*TAG_W +: TAG_W] == tags[o*TAG_W +: TAG_W]) begin
                        ops_n[o*OP_W +: OP_W]   = pros_data[p*OP_W +: OP_W];
                        tags_n[o*TAG_W +: TAG_W] = TAG_W'(TAG_RESOLVED);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/m_ex_wakeup_queue.sv
// In-order M->EX holding queue with wake snooping and operand forwarding.
// Defining M_EX_Q_FLUSH_EN adds a synchronous flush port.
module m_ex_wakeup_queue
    import m_ex_q_pkg::*;
#(
    parameter int DEPTH    = DEPTH_D,
    parameter int NUM_OPS  = NUM_OPS_D,
    parameter int OP_W     = OP_W_D,
    parameter int TAG_W    = TAG_W_D,
    parameter int ID_W     = ID_W_D,
    parameter int NUM_WAKE = NUM_WAKE_D,
    parameter int NUM_PROS = NUM_PROS_D,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      clr,
    m_ex_wakeup_queue_if.slave        q,
    input  logic [ID_W-1:0]           cache_id,
    input  logic [NUM_WAKE-1:0]       cache_wake,
    input  logic [ID_W-1:0]           mshr_id,
    input  logic [NUM_WAKE-1:0]       mshr_wake,
    input  logic [NUM_PROS*OP_W-1:0]  pros_data,
    input  logic [NUM_PROS*TAG_W-1:0] pros_tag,
`ifdef M_EX_Q_FLUSH_EN
    input  logic                      flush,
`endif
    output logic [PTR_W:0]            count
);
    entry_t               ent [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       cnt;
    logic [NUM_OPS*OP_W-1:0]  fwd_ops  [DEPTH];
    logic [NUM_OPS*TAG_W-1:0] fwd_tags [DEPTH];
    logic [NUM_OPS*OP_W-1:0]  in_ops_f;
    logic [NUM_OPS*TAG_W-1:0] in_tags_f;
    logic                     enq;
    logic                     deq;
    logic                     flush_now;

    function automatic logic [NUM_WAKE-1:0] wake_of(
        input logic [ID_W-1:0] id,
        input logic [ID_W-1:0] c_id, input logic [NUM_WAKE-1:0] c_wk,
        input logic [ID_W-1:0] m_id, input logic [NUM_WAKE-1:0] m_wk
    );
        return ((id == c_id) ? c_wk : '0) | ((id == m_id) ? m_wk : '0);
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
        m_ex_q_fwd #(
            .NUM_OPS(NUM_OPS), .OP_W(OP_W), .TAG_W(TAG_W), .NUM_PROS(NUM_PROS)
        ) u_fwd (
            .ops(ent[g].ops), .tags(ent[g].tags),
            .pros_data(pros_data), .pros_tag(pros_tag),
            .ops_n(fwd_ops[g]), .tags_n(fwd_tags[g])
        );
    end

    m_ex_q_fwd #(
        .NUM_OPS(NUM_OPS), .OP_W(OP_W), .TAG_W(TAG_W), .NUM_PROS(NUM_PROS)
    ) u_fwd_in (
        .ops(q.in_ops), .tags(q.in_tags),
        .pros_data(pros_data), .pros_tag(pros_tag),
        .ops_n(in_ops_f), .tags_n(in_tags_f)
    );

`ifdef M_EX_Q_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    assign q.in_ready  = (cnt != (PTR_W+1)'(DEPTH));
    assign q.out_valid = entry_ready(ent[head]);
    assign q.out_id    = ent[head].id;
    assign q.out_ops   = ent[head].ops;
    assign count       = cnt;
    assign enq         = q.in_valid && q.in_ready;
    assign deq         = q.out_valid && q.out_ready;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent[i].valid) begin
                    ent[i].wake <= ent[i].wake | wake_of(ent[i].id,
                        cache_id, cache_wake, mshr_id, mshr_wake);
                    ent[i].ops  <= fwd_ops[i];
                    ent[i].tags <= fwd_tags[i];
                end
            end
            if (deq) begin
                ent[head].valid <= 1'b0;
                head <= head + 1'b1;
            end
            // Enqueue slot is never the live head, so this cannot clash.
            if (enq) begin
                ent[tail] <= '{
                    valid: 1'b1,
                    id:    q.in_id,
                    need:  q.in_need,
                    wake:  wake_of(q.in_id, cache_id, cache_wake,
                                   mshr_id, mshr_wake),
                    ops:   in_ops_f,
                    tags:  in_tags_f
                };
                tail <= tail + 1'b1;
            end
            cnt <= cnt + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
        end
    end
endmodule

// File: tb/tb_m_ex_wakeup_queue.sv
// Directed scoreboard bench for m_ex_wakeup_queue.
// Flush steps run only when M_EX_Q_FLUSH_EN is defined.
module tb_m_ex_wakeup_queue;
    typedef struct packed {
        logic [6:0]  id;
        logic [63:0] op0;
    } exp_t;

    logic        clk;
    logic        clr;
    logic [6:0]  cache_id;
    logic [3:0]  cache_wake;
    logic [6:0]  mshr_id;
    logic [3:0]  mshr_wake;
    logic [447:0] pros_data;
    logic [55:0]  pros_tag;
    logic [3:0]   count;
`ifdef M_EX_Q_FLUSH_EN
    logic         flush;
`endif

    int   nvec;
    int   nerr;
    exp_t sb [$];

    m_ex_wakeup_queue_if qif ();

    m_ex_wakeup_queue dut (
        .clk(clk), .clr(clr), .q(qif),
        .cache_id(cache_id), .cache_wake(cache_wake),
        .mshr_id(mshr_id), .mshr_wake(mshr_wake),
        .pros_data(pros_data), .pros_tag(pros_tag),
`ifdef M_EX_Q_FLUSH_EN
        .flush(flush),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [6:0] id, input logic [3:0] need,
                       input logic [7:0] tag0, input logic [63:0] op0,
                       input logic [63:0] exp_op0);
        exp_t e;
        qif.in_valid = 1'b1;
        qif.in_id    = id;
        qif.in_need  = need;
        qif.in_ops   = {192'h0, op0};
        qif.in_tags  = {24'h0, tag0};
        e.id  = id;
        e.op0 = exp_op0;
        sb.push_back(e);
        tick();
        qif.in_valid = 1'b0;
    endtask

    task automatic check_head(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 64'(qif.out_valid), 64'd1);
        chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, 64'(qif.out_id), 64'(e.id));
            chk({tag, "_op0"}, qif.out_ops[63:0], e.op0);
        end
    endtask

    task automatic drain(input string tag);
        check_head(tag);
        qif.out_ready = 1'b1;
        tick();
        qif.out_ready = 1'b0;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clr = 1'b0;
        qif.in_valid = 1'b0;
        qif.in_id = '0;
        qif.in_need = '0;
        qif.in_ops = '0;
        qif.in_tags = '0;
        qif.out_ready = 1'b0;
        cache_id = '0;
        cache_wake = '0;
        mshr_id = '0;
        mshr_wake = '0;
        pros_data = '0;
        pros_tag = '0;
`ifdef M_EX_Q_FLUSH_EN
        flush = 1'b0;
`endif
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(qif.out_valid), 64'd0);
        chk("rst_in_ready", 64'(qif.in_ready), 64'd1);
        tick();
        clr = 1'b1;
        tick();

        // wake from cache then MSHR
        enq(7'd5, 4'b0011, 8'h00, 64'h55, 64'h55);
        chk("w_count", 64'(count), 64'd1);
        chk("w_notready0", 64'(qif.out_valid), 64'd0);
        cache_id = 7'd5;
        cache_wake = 4'b0001;
        tick();
        cache_wake = '0;
        chk("w_notready1", 64'(qif.out_valid), 64'd0);
        mshr_id = 7'd5;
        mshr_wake = 4'b0010;
        tick();
        mshr_wake = '0;
        drain("wake");

        // forwarding from prospect 2
        enq(7'd1, 4'b0000, 8'h12, 64'h0, 64'hDEAD);
        chk("f_notready", 64'(qif.out_valid), 64'd0);
        pros_tag[2*8 +: 8] = 8'h12;
        pros_data[2*64 +: 64] = 64'hDEAD;
        tick();
        pros_tag = '0;
        pros_data = '0;
        drain("fwd");

        // two matching prospects, lowest index wins
        enq(7'd2, 4'b0000, 8'h20, 64'h0, 64'h1);
        pros_tag[1*8 +: 8] = 8'h20;
        pros_data[1*64 +: 64] = 64'h1;
        pros_tag[4*8 +: 8] = 8'h20;
        pros_data[4*64 +: 64] = 64'h4;
        tick();
        pros_tag = '0;
        pros_data = '0;
        drain("prio");

        // resolved operand does not rematch
        enq(7'd3, 4'b0001, 8'h30, 64'h0, 64'hA);
        pros_tag[0 +: 8] = 8'h30;
        pros_data[0 +: 64] = 64'hA;
        tick();
        pros_data[0 +: 64] = 64'hB;
        tick();
        pros_tag = '0;
        pros_data = '0;
        cache_id = 7'd3;
        cache_wake = 4'b0001;
        tick();
        cache_wake = '0;
        drain("rematch");

        // fill to full from a reset state, then wrap
        clr = 1'b0;
        #1;
        clr = 1'b1;
        for (int i = 0; i < 8; i++)
            enq(7'(10 + i), 4'b0000, 8'h00, 64'(i), 64'(i));
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(qif.in_ready), 64'd0);
        check_head("full_deq");
        qif.in_valid = 1'b1;
        qif.in_id = 7'd18;
        qif.in_need = '0;
        qif.in_ops = {192'h0, 64'h18};
        qif.in_tags = '0;
        qif.out_ready = 1'b1;
        tick();
        qif.out_ready = 1'b0;
        chk("full_nopass", 64'(count), 64'd7);
        chk("full_ready_again", 64'(qif.in_ready), 64'd1);
        sb.push_back('{id: 7'd18, op0: 64'h18});
        tick();
        qif.in_valid = 1'b0;
        chk("wrap_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) drain("wrap_drain");
        chk("wrap_empty", 64'(count), 64'd0);

        // head blocks younger ready entry
        enq(7'd20, 4'b0001, 8'h00, 64'h20, 64'h20);
        enq(7'd21, 4'b0000, 8'h00, 64'h21, 64'h21);
        tick();
        chk("blk_valid", 64'(qif.out_valid), 64'd0);
        chk("blk_count", 64'(count), 64'd2);
        cache_id = 7'd20;
        cache_wake = 4'b0001;
        tick();
        cache_wake = '0;
        drain("blk_head");
        drain("blk_next");

        // wake in enqueue cycle, then async clear
        cache_id = 7'd9;
        cache_wake = 4'b0011;
        enq(7'd9, 4'b0011, 8'h00, 64'h9, 64'h9);
        cache_wake = '0;
        chk("enqwake_valid", 64'(qif.out_valid), 64'd1);
        enq(7'd30, 4'b0000, 8'h00, 64'h30, 64'h30);
        chk("pre_clr_count", 64'(count), 64'd2);
        #2;
        clr = 1'b0;
        #1;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_out_valid", 64'(qif.out_valid), 64'd0);
        sb.delete();
        clr = 1'b1;
        tick();

`ifdef M_EX_Q_FLUSH_EN
        enq(7'd40, 4'b0000, 8'h00, 64'h40, 64'h40);
        enq(7'd41, 4'b0000, 8'h00, 64'h41, 64'h41);
        chk("pre_flush_count", 64'(count), 64'd2);
        flush = 1'b1;
        qif.in_valid = 1'b1;
        qif.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        qif.in_valid = 1'b0;
        qif.out_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(qif.out_valid), 64'd0);
        sb.delete();
        enq(7'd42, 4'b0000, 8'h00, 64'h42, 64'h42);
        drain("post_flush");
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
